// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-to-EX operand-select bus: decode-stage register usage in, EX forward codes and stall out.
// The design (slave) computes forwarding and hazards; the pipeline/driver side is the master.
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
        input  fwd_a, fwd_b, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
        output fwd_a, fwd_b, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding-code producer with load-use stall detection and bubble injection.
// Optional macro FWD_ZERO_REG_EN: source index 0 selects the constant-zero mux leg (code 11).
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_ctrl_if.slave   bus
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

    stage_t ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic stall_c;
    logic bubble;

    // A load in EX whose result decode needs cannot be forwarded in time.
    assign stall_c = bus.id_valid && ex_q.memread && (ex_q.rd != '0) &&
                     ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));
    assign bubble  = stall_c || bus.flush;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.rd       = bus.id_rd;
            ex_d.regwrite = bus.id_regwrite & bus.id_valid;
            ex_d.memread  = bus.id_memread & bus.id_valid;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && !bus.flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // One forward-code generator per source operand: gi = 0 -> rs1/fwd_a, gi = 1 -> rs2/fwd_b.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [REG_AW-1:0] src;
            logic              ex_hit;
            logic              mem_hit;
            logic              zero_src;
            logic [1:0]        code_d;
            logic [1:0]        code_q;

            assign src     = (gi == 0) ? bus.id_rs1 : bus.id_rs2;
            assign ex_hit  = ex_q.regwrite && (ex_q.rd == src) && (ex_q.rd != '0);
            assign mem_hit = mem_q.regwrite && (mem_q.rd == src) && (mem_q.rd != '0);
`ifdef FWD_ZERO_REG_EN
            assign zero_src = (src == '0);
`else
            assign zero_src = 1'b0;
`endif

            // The instruction now in EX will sit in MEM next cycle, so it is the freshest producer.
            always_comb begin
                code_d = 2'b00;
                if (zero_src) begin
                    code_d = 2'b11;
                end else if (ex_hit) begin
                    code_d = 2'b01;
                end else if (mem_hit) begin
                    code_d = 2'b10;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    code_q <= 2'b00;
                end else if (bubble) begin
                    code_q <= 2'b00;
                end else begin
                    code_q <= code_d;
                end
            end
        end
    endgenerate

    assign bus.fwd_a     = g_fwd[0].code_q;
    assign bus.fwd_b     = g_fwd[1].code_q;
    assign bus.stall     = stall_c;
    assign bus.stall_cnt = stall_cnt_q;

    // WB is tracked for pipeline alignment only; its write lands before the register read.
    logic unused_stage;
    assign unused_stage = ^{wb_q, mem_q.memread};

endmodule
